// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, persistent {Z,N,C,V} status,
// HI/LO product registers and a multi-cycle shift-add unsigned multiply.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [3:0]       i_opcode,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt_cnst,
    input  logic [SHW-1:0]   i_shamt,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_rd,
    output logic [3:0]       o_sr,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_err
);
    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_t             r_state;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_rd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [3:0]         r_sr;
    logic               r_out_valid;
    logic               r_err;

    logic               w_accept;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_sll;
    logic [WIDTH:0]     w_srl;
    logic               w_add_v;
    logic               w_sub_v;
    logic               w_cadd;
    logic [WIDTH-1:0]   w_rd;
    logic               w_c;
    logic               w_v;
    logic               w_upd;
    logic               w_err;
    logic [3:0]         w_sr;
    logic [2*WIDTH-1:0] w_acc;
    logic [WIDTH-1:0]   w_prod_hi;

    assign o_in_ready  = (r_state == IDLE) && (!r_out_valid || i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_rd        = r_rd;
    assign o_sr        = r_sr;
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;
    assign o_err       = r_err;

    // Extra top bit carries the carry/borrow; shifts keep the last bit shifted out.
    assign w_add   = {1'b0, i_rs} + {1'b0, i_rt_cnst};
    assign w_sub   = {1'b0, i_rs} - {1'b0, i_rt_cnst};
    assign w_sll   = {1'b0, i_rs} << i_shamt;
    assign w_srl   = {i_rs, 1'b0} >> i_shamt;
    assign w_add_v = (i_rs[WIDTH-1] == i_rt_cnst[WIDTH-1]) && (w_add[WIDTH-1] != i_rs[WIDTH-1]);
    assign w_sub_v = (i_rs[WIDTH-1] != i_rt_cnst[WIDTH-1]) && (w_sub[WIDTH-1] != i_rs[WIDTH-1]);
    assign w_cadd  = r_sr[3] || r_sr[2];

    always_comb begin
        w_rd  = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = w_add_v;
        w_upd = 1'b1;
        w_err = 1'b0;
        case (i_opcode)
            4'd1:  begin w_rd = w_sll[WIDTH-1:0]; w_c = w_sll[WIDTH]; w_v = 1'b0; end
            4'd2:  begin w_rd = w_srl[WIDTH:1]; w_c = w_srl[0]; w_v = 1'b0; end
            4'd3:  begin w_rd = i_rs | i_rt_cnst; w_c = 1'b0; w_v = 1'b0; end
            4'd4:  begin w_rd = i_rs & i_rt_cnst; w_c = 1'b0; w_v = 1'b0; end
            4'd6:  begin w_rd = i_rt_cnst; w_c = 1'b0; w_v = 1'b0; end
            4'd11: begin w_rd = r_lo; w_upd = 1'b0; end
            4'd12: begin w_rd = r_hi; w_upd = 1'b0; end
            4'd13: begin w_rd = w_cadd ? w_add[WIDTH-1:0] : i_rs; w_upd = w_cadd; end
            4'd14: begin w_rd = w_sub[WIDTH-1:0]; w_c = w_sub[WIDTH]; w_v = w_sub_v; end
            4'd9, 4'd15: begin w_rd = '0; w_upd = 1'b0; w_err = 1'b1; end
            default: ;
        endcase
    end

    assign w_sr      = w_upd ? {w_rd == '0, w_rd[WIDTH-1], w_c, w_v} : r_sr;
    assign w_acc     = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_hi = w_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplier    <= '0;
            r_rd        <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_sr        <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (i_out_ready)
                r_out_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept && i_opcode == 4'd10) begin
                    r_state  <= MUL;
                    r_cnt    <= '0;
                    r_mcand  <= {{WIDTH{1'b0}}, i_rs};
                    r_mplier <= i_rt_cnst;
                    r_acc    <= '0;
                end else if (w_accept) begin
                    r_rd        <= w_rd;
                    r_sr        <= w_sr;
                    r_err       <= w_err;
                    r_out_valid <= 1'b1;
                end
            end else if (r_cnt == LAST) begin
                // Final partial product is folded in while loading the result.
                r_state     <= IDLE;
                r_hi        <= w_prod_hi;
                r_lo        <= w_acc[WIDTH-1:0];
                r_rd        <= w_acc[WIDTH-1:0];
                r_sr        <= {w_acc == '0, w_acc[2*WIDTH-1], |w_prod_hi, |w_prod_hi};
                r_err       <= 1'b0;
                r_out_valid <= 1'b1;
            end else begin
                r_acc    <= w_acc;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed examples plus randomized ops against an arithmetic reference model;
// a negedge monitor checks every result, its latency and the in_ready handshake.
module tb_alu_seq;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] rd;
        logic [3:0]   sr;
        logic         err;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           acc;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_in_valid = 1'b0;
    logic         i_out_ready = 1'b1;
    logic [3:0]   i_opcode = '0;
    logic [W-1:0] i_rs = '0;
    logic [W-1:0] i_rt_cnst = '0;
    logic [3:0]   i_shamt = '0;
    logic         o_in_ready;
    logic         o_out_valid;
    logic [W-1:0] o_rd;
    logic [3:0]   o_sr;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;
    logic         o_err;

    exp_t         q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           rdy_mode = 0;
    bit           seen = 0;
    bit           mul_pend = 0;
    logic [3:0]   m_sr = '0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_opcode(i_opcode), .i_rs(i_rs), .i_rt_cnst(i_rt_cnst), .i_shamt(i_shamt),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_rd(o_rd), .o_sr(o_sr), .o_hi(o_hi), .o_lo(o_lo), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        i_out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(3) != 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: the ALU as plain integer arithmetic, applied in accept order.
    function automatic exp_t model_step(input logic [3:0] op, input int unsigned a, b, sh);
        exp_t e;
        int unsigned r = 0;
        longint unsigned p = 0;
        int sa, sb, s;
        bit c = 0, v = 0, upd = 1;
        sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
        e.err = 1'b0;
        e.lat = 1;
        e.acc = 0;
        if (op == 13 && !(m_sr[3] || m_sr[2])) begin
            r = a;
            upd = 0;
        end else begin
            case (op)
                0, 5, 7, 8, 13: begin
                    r = (a + b) % 65536; c = (a + b) > 65535;
                    s = sa + sb; v = (s > 32767) || (s < -32768);
                end
                1: begin r = (a << sh) % 65536; c = (sh != 0) && ((a >> (16 - sh)) % 2 == 1); end
                2: begin r = a >> sh; c = (sh != 0) && ((a >> (sh - 1)) % 2 == 1); end
                3: r = a | b;
                4: r = a & b;
                6: r = b;
                10: begin
                    p = longint'(a) * longint'(b);
                    m_hi = 16'(p >> 16); m_lo = 16'(p % 65536);
                    r = m_lo; upd = 0; e.lat = 17;
                end
                11: begin r = m_lo; upd = 0; end
                12: begin r = m_hi; upd = 0; end
                14: begin
                    r = (a - b) % 65536; c = a < b;
                    s = sa - sb; v = (s > 32767) || (s < -32768);
                end
                default: begin r = 0; upd = 0; e.err = 1'b1; end
            endcase
        end
        if (op == 10) m_sr = {p == 0, m_hi[15], m_hi != 0, m_hi != 0};
        else if (upd) m_sr = {r == 0, r[15], c, v};
        e.rd = 16'(r);
        e.sr = m_sr;
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, b, input logic [3:0] sh,
                        output int n);
        exp_t e;
        n = 0;
        @(negedge clk);
        #1;
        i_in_valid = 1'b1; i_opcode = op; i_rs = a; i_rt_cnst = b; i_shamt = sh;
        while (!o_in_ready) begin
            if (++n > 200) begin
                chk("accept_timeout", o_in_ready, 1);
                i_in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        e = model_step(op, a, b, sh);
        e.acc = cyc;
        q.push_back(e);
        if (op == 10) mul_pend = 1;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        i_rs = $urandom; i_rt_cnst = $urandom;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!o_out_valid) chk("wait_valid", o_out_valid, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_out_valid) begin
                if (q.size() == 0) chk("spurious_valid", o_out_valid, 0);
                else begin
                    if (!seen) begin
                        seen = 1;
                        chk("latency", cyc - q[0].acc, q[0].lat);
                        if (q[0].lat == 17) mul_pend = 0;
                    end
                    chk("rd", o_rd, q[0].rd);
                    chk("sr", o_sr, q[0].sr);
                    chk("err", o_err, q[0].err);
                    chk("hi", o_hi, q[0].hi);
                    chk("lo", o_lo, q[0].lo);
                    if (i_out_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
            chk("in_ready", o_in_ready, !mul_pend && (!o_out_valid || i_out_ready));
        end
    end

    initial begin
        int n;
        logic [3:0] op;
        logic [3:0] sh;
        logic [W-1:0] a, b;
        @(posedge clk);
        #1;
        chk("rst_rd", o_rd, 0);
        chk("rst_sr", o_sr, 0);
        chk("rst_hi", o_hi, 0);
        chk("rst_lo", o_lo, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_err", o_err, 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        chk("rst_in_ready", o_in_ready, 1);

        send(4'd0, 16'hFFFF, 16'h0001, 4'd0, n); wait_valid();
        chk("ex1_rd", o_rd, 16'h0000); chk("ex1_sr", o_sr, 4'b1010);
        send(4'd13, 16'h0002, 16'h0003, 4'd0, n); wait_valid();
        chk("cadd_z_rd", o_rd, 16'h0005); chk("cadd_z_sr", o_sr, 4'b0000);
        send(4'd13, 16'h0007, 16'h0009, 4'd0, n); wait_valid();
        chk("cadd_nz_rd", o_rd, 16'h0007); chk("cadd_nz_sr", o_sr, 4'b0000);
        send(4'd9, 16'h1111, 16'h2222, 4'd0, n); wait_valid();
        chk("rsv_rd", o_rd, 16'h0000); chk("rsv_err", o_err, 1);
        send(4'd0, 16'h7FFF, 16'h0001, 4'd0, n); wait_valid();
        chk("ex2_add_rd", o_rd, 16'h8000); chk("ex2_add_sr", o_sr, 4'b0101);
        send(4'd14, 16'h0003, 16'h0005, 4'd0, n); wait_valid();
        chk("ex2_sub_rd", o_rd, 16'hFFFE); chk("ex2_sub_sr", o_sr, 4'b0110);
        send(4'd10, 16'h1234, 16'h5678, 4'd0, n); wait_valid();
        chk("ex3_rd", o_rd, 16'h0060); chk("ex3_hi", o_hi, 16'h0626);
        chk("ex3_lo", o_lo, 16'h0060); chk("ex3_sr", o_sr, 4'b0011);
        send(4'd12, 16'h0000, 16'h0000, 4'd0, n); wait_valid();
        chk("ex3_mfhi", o_rd, 16'h0626);

        rdy_mode = 2;
        @(posedge clk);
        #2;
        send(4'd0, 16'h000A, 16'h0014, 4'd0, n);
        repeat (5) @(negedge clk);
        chk("bp_in_ready", o_in_ready, 0);
        chk("bp_rd", o_rd, 16'h001E);
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) begin
            send(4'd0, 16'(i), 16'(3 * i), 4'd0, n);
            if (i > 0) chk("b2b_stall", n, 0);
        end

        send(4'd10, 16'hABCD, 16'h1357, 4'd0, n);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_rd", o_rd, 0);
        chk("mrst_sr", o_sr, 0);
        chk("mrst_hi", o_hi, 0);
        chk("mrst_lo", o_lo, 0);
        chk("mrst_out_valid", o_out_valid, 0);
        chk("mrst_err", o_err, 0);
        q.delete(); mul_pend = 0; seen = 0; m_sr = '0; m_hi = '0; m_lo = '0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mrst_no_result", o_out_valid, 0);
        send(4'd0, 16'd100, 16'd23, 4'd0, n); wait_valid();
        chk("mrst_add", o_rd, 16'd123);

        rdy_mode = 1;
        for (int k = 0; k < 300; k++) begin
            op = 4'($urandom_range(15));
            a = pick();
            b = pick();
            sh = 4'($urandom_range(15));
            send(op, a, b, sh, n);
            if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(negedge clk);
        end
        for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
        chk("drain", q.size(), 0);
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
